mem_io_bus: RTL and testbench



---
 rtl/mem_io_bus.sv | 117 +++++++++++
 tb/tb_mem_io_bus.sv | 195 +++++++++++++++++++
 2 files changed

// File: rtl/mem_io_bus.sv
// mem_io_bus: data-side bus slave decoding a word RAM, a cycle counter and a UART TX page
// Ports: clock/reset (synchronous, active-high); addr/wval/write from the core;
//        rval combinational load data; tx UART serial line (idle high).
// Define MEM_IO_BUS_UART_EN to build the TX FIFO, transmitter FSM and DATA/STATUS registers.
module mem_io_bus #(
    parameter int RAM_WORDS  = 1024,
    parameter int CLK_DIV    = 434,
    parameter int FIFO_DEPTH = 8
) (
    input  logic        clock,
    input  logic        reset,
    input  logic [31:0] addr,
    input  logic [31:0] wval,
    input  logic        write,
    output logic [31:0] rval,
    output logic        tx
);
    localparam int AW = $clog2(RAM_WORDS);
    logic [31:0] ram [RAM_WORDS];
    logic [31:0] cycles;
    logic [31:0] status;
    logic        sel_ram;
    logic        sel_status;
    logic        sel_cycles;
    assign sel_ram    = addr[31:28] == 4'h0;
    assign sel_status = addr == 32'hF000_0004;
    assign sel_cycles = addr == 32'hF000_0008;
    always_ff @(posedge clock) begin
        if (write && sel_ram) ram[addr[2 +: AW]] <= wval;
    end
    always_ff @(posedge clock) begin
        if (reset) cycles <= 32'h0;
        else cycles <= (write && sel_cycles) ? wval : cycles + 32'd1;
    end
    assign rval = sel_ram ? ram[addr[2 +: AW]] : sel_status ? status : sel_cycles ? cycles : 32'h0;
`ifdef MEM_IO_BUS_UART_EN
    localparam int FW = $clog2(FIFO_DEPTH);
    localparam int CW = FW + 1;
    localparam int DW = $clog2(CLK_DIV);
    localparam int DIV_MAX = CLK_DIV - 1;
    localparam logic [DW-1:0] DIV_LAST = DIV_MAX[DW-1:0];
    localparam logic [CW-1:0] FULL_CNT = FIFO_DEPTH[CW-1:0];
    typedef enum logic [1:0] {IDLE, START, DATA, STOP} state_t;
    state_t          state;
    state_t          state_n;
    logic [7:0]      fifo [FIFO_DEPTH];
    logic [FW-1:0]   rd_ptr;
    logic [FW-1:0]   wr_ptr;
    logic [CW-1:0]   count;
    logic [DW-1:0]   div;
    logic [2:0]      bit_cnt;
    logic [7:0]      shift;
    logic            ovf;
    logic            full;
    logic            empty;
    logic            div_last;
    logic            pop;
    logic            push_req;
    logic            push;
    assign full     = count == FULL_CNT;
    assign empty    = count == '0;
    assign div_last = div == DIV_LAST;
    // Pops happen from IDLE or at the last STOP cycle, so frames chain with no gap.
    assign pop      = !empty && (state == IDLE || (state == STOP && div_last));
    assign push_req = write && addr == 32'hF000_0000;
    // A pop in the same cycle frees the slot a full FIFO would otherwise refuse.
    assign push     = push_req && (!full || pop);
    assign status   = {20'h0, 4'(count), 4'h0, ovf, state != IDLE, empty, full};
    assign tx       = state == START ? 1'b0 : state == DATA ? shift[0] : 1'b1;
    always_ff @(posedge clock) begin
        if (push) fifo[wr_ptr] <= wval[7:0];
    end
    always_ff @(posedge clock) begin
        if (reset) begin
            rd_ptr <= '0;
            wr_ptr <= '0;
            count  <= '0;
        end else begin
            if (push) wr_ptr <= wr_ptr + FW'(1);
            if (pop) rd_ptr <= rd_ptr + FW'(1);
            count <= count + CW'(push) - CW'(pop);
        end
    end
    always_ff @(posedge clock) begin
        if (reset) state <= IDLE;
        else state <= state_n;
    end
    always_comb begin
        state_n = state;
        case (state)
            IDLE:    state_n = empty ? IDLE : START;
            START:   state_n = div_last ? DATA : START;
            DATA:    state_n = (div_last && bit_cnt == 3'd7) ? STOP : DATA;
            STOP:    state_n = div_last ? (empty ? IDLE : START) : STOP;
            default: state_n = IDLE;
        endcase
    end
    // Every state change other than leaving IDLE happens on the last divider count,
    // so wrapping there (and holding zero in IDLE) restarts the divider on each entry.
    always_ff @(posedge clock) begin
        if (reset) begin
            div     <= '0;
            bit_cnt <= 3'd0;
            shift   <= 8'h0;
            ovf     <= 1'b0;
        end else begin
            div     <= (state == IDLE || div_last) ? '0 : div + DW'(1);
            bit_cnt <= state != DATA ? 3'd0 : div_last ? bit_cnt + 3'd1 : bit_cnt;
            shift   <= pop ? fifo[rd_ptr] : (state == DATA && div_last) ? shift >> 1 : shift;
            ovf     <= (push_req && !push) ? 1'b1 : (write && sel_status && wval[3]) ? 1'b0 : ovf;
        end
    end
`else
    assign status = 32'h0000_0002;
    assign tx     = 1'b1;
`endif
endmodule

// File: tb/tb_mem_io_bus.sv
// tb_mem_io_bus: directed bench for mem_io_bus with a frame-level reference model
module tb_mem_io_bus;
    localparam int D     = 4;
    localparam int DEPTH = 8;
    localparam int WORDS = 1024;
`ifdef MEM_IO_BUS_UART_EN
    localparam bit UART = 1'b1;
`else
    localparam bit UART = 1'b0;
`endif
    logic        clk = 1'b0;
    logic        reset;
    logic        write;
    logic        tx;
    logic [31:0] addr;
    logic [31:0] wval;
    logic [31:0] rval;
    mem_io_bus #(.RAM_WORDS(WORDS), .CLK_DIV(D), .FIFO_DEPTH(DEPTH)) dut (
        .clock(clk), .reset(reset), .addr(addr), .wval(wval),
        .write(write), .rval(rval), .tx(tx)
    );
    always #5 clk = ~clk;
    int n_run = 0;
    int n_fail = 0;
    logic [31:0] m_ram [WORDS];
    bit          m_ok [WORDS];
    logic [31:0] m_cyc;
    logic [7:0]  m_q [$];
    bit          m_ovf;
    bit          m_busy;
    int          m_t;
    logic [7:0]  m_cur;
    logic [9:0]  f55 = 10'h2AA;
    function automatic bit m_pop();
        return UART && m_q.size() > 0 && (!m_busy || m_t == 10 * D - 1);
    endfunction
    function automatic logic m_tx();
        int j;
        if (!m_busy) return 1'b1;
        j = m_t / D;
        if (j == 0) return 1'b0;
        if (j == 9) return 1'b1;
        return m_cur[j - 1];
    endfunction
    function automatic logic [31:0] m_status();
        if (!UART) return 32'h2;
        return {20'h0, 4'(m_q.size()), 4'h0, m_ovf, m_busy, m_q.size() == 0, m_q.size() == DEPTH};
    endfunction
    function automatic logic [31:0] m_rval(input logic [31:0] a);
        if (a[31:28] == 4'h0) return m_ram[a[11:2]];
        if (a == 32'hF000_0004) return m_status();
        if (a == 32'hF000_0008) return m_cyc;
        return 32'h0;
    endfunction
    task automatic model_step();
        bit pop;
        bit push_req;
        bit acc;
        if (reset) begin
            m_q.delete();
            m_busy = 0;
            m_t = 0;
            m_ovf = 0;
            m_cyc = 32'h0;
            return;
        end
        pop = m_pop();
        push_req = UART && write && addr == 32'hF000_0000;
        acc = push_req && (m_q.size() < DEPTH || pop);
        if (write && addr[31:28] == 4'h0) begin
            m_ram[addr[11:2]] = wval;
            m_ok[addr[11:2]] = 1;
        end
        m_cyc = (write && addr == 32'hF000_0008) ? wval : m_cyc + 32'd1;
        if (UART && write && addr == 32'hF000_0004 && wval[3]) m_ovf = 0;
        if (push_req && !acc) m_ovf = 1;
        if (m_busy) begin
            m_t++;
            if (m_t == 10 * D) m_busy = 0;
        end
        if (pop) begin
            m_cur = m_q.pop_front();
            m_busy = 1;
            m_t = 0;
        end
        if (acc) m_q.push_back(wval[7:0]);
    endtask
    task automatic check(input string name, input logic [31:0] got, input logic [31:0] exp);
        n_run++;
        if (got !== exp) begin
            n_fail++;
            $display("FAIL %s at %0t: got %h expected %h", name, $time, got, exp);
        end
    endtask
    task automatic check_all();
        check("model_tx", {31'h0, tx}, {31'h0, m_tx()});
        if (addr[31:28] != 4'h0 || m_ok[addr[11:2]]) check("model_rval", rval, m_rval(addr));
    endtask
    task automatic tick();
        @(posedge clk);
        model_step();
        #1;
        check_all();
    endtask
    task automatic set(input logic [31:0] a, input logic [31:0] v, input logic w);
        addr = a;
        wval = v;
        write = w;
        #1;
    endtask
    initial begin
        reset = 1'b1;
        write = 1'b0;
        addr = 32'h0;
        wval = 32'h0;
        tick();
        tick();
        check("reset_tx", {31'h0, tx}, 32'h1);
        reset = 1'b0;
        set(32'hF000_0004, 0, 0);
        check("reset_status", rval, 32'h2);
        set(32'hF000_0008, 0, 0);
        check("reset_cycles", rval, 32'h0);
        tick();
        check("cycles_inc", rval, 32'h1);
        set(32'h0000_0010, 32'hDEAD_BEEF, 1);
        tick();
        set(32'h0000_0013, 0, 0);
        check("ram_read", rval, 32'hDEAD_BEEF);
        set(32'h0000_1010, 0, 0);
        check("ram_alias", rval, 32'hDEAD_BEEF);
        set(32'h8000_0000, 0, 0);
        check("unmapped_hi", rval, 32'h0);
        set(32'hF000_000C, 0, 0);
        check("unmapped_io", rval, 32'h0);
        set(32'hF000_0000, 0, 0);
        check("data_read", rval, 32'h0);
        set(32'hF000_0008, 32'hFFFF_FFFE, 1);
        tick();
        set(32'hF000_0008, 0, 0);
        check("cycles_load", rval, 32'hFFFF_FFFE);
        tick();
        check("cycles_max", rval, 32'hFFFF_FFFF);
        tick();
        check("cycles_wrap", rval, 32'h0);
        set(32'hF000_0000, 32'h55, 1);
        tick();
        set(32'hF000_0004, 0, 0);
        for (int i = 1; i <= 40; i++) begin
            tick();
            check("frame_55", {31'h0, tx}, {31'h0, UART ? f55[(i - 1) / D] : 1'b1});
        end
        tick();
        check("frame_done_status", rval, 32'h2);
        for (int i = 0; i < 10; i++) begin
            set(32'hF000_0000, 32'hA0 + i, 1);
            tick();
        end
        set(32'hF000_0004, 0, 0);
        check("ovf_status", rval, UART ? 32'h80D : 32'h2);
        set(32'hF000_0004, 32'h8, 1);
        tick();
        set(32'hF000_0004, 0, 0);
        check("ovf_clear", rval, UART ? 32'h805 : 32'h2);
        for (int i = 0; i < 200 && !m_pop(); i++) tick();
        check("pop_wait", {31'h0, m_pop()}, {31'h0, UART});
        set(32'hF000_0000, 32'h77, 1);
        tick();
        set(32'hF000_0004, 0, 0);
        check("push_pop_full", rval, UART ? 32'h805 : 32'h2);
        for (int i = 0; i < 11 * 10 * D; i++) tick();
        check("drain_status", rval, 32'h2);
        set(32'hF000_0000, 32'h31, 1);
        tick();
        set(32'hF000_0000, 32'h32, 1);
        tick();
        set(32'hF000_0000, 32'h33, 1);
        tick();
        set(32'hF000_0004, 0, 0);
        for (int i = 0; i < 16; i++) tick();
        check("bit3_tx", {31'h0, tx}, {31'h0, !UART});
        reset = 1'b1;
        tick();
        reset = 1'b0;
        #1;
        check("abort_tx", {31'h0, tx}, 32'h1);
        check("abort_status", rval, 32'h2);
        for (int i = 0; i < 100; i++) begin
            tick();
            check("no_frame", {31'h0, tx}, 32'h1);
        end
        $display("[TB] %0d tests run, %0d failed", n_run, n_fail);
        $finish;
    end
endmodule
